regfile_writeback: RTL and testbench

Write-side front end for the 32-entry register file. Accepts destination-register results from the ALU and the load unit over valid/ready handshakes, buffers them in a small in-order queue, and drains one entry per cycle into the register file's single write port (write address, write data, write enable). Read operands are bypassed from queued entries not yet written, so the decode stage sees up-to-date values.

---
 rtl/regfile_writeback.sv | 123 ++++++++++++
 tb/tb_regfile_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-side front end for the 32-entry register file: arbitrates ALU/load results
// into an in-order queue, drains one entry per cycle, and bypasses queued data to reads.
module regfile_writeback #(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 4,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [4:0]           alu_rd,
  input  logic [REG_WIDTH-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd,
  input  logic [REG_WIDTH-1:0] ld_data,
  input  logic                 hold,
  output logic [4:0]           wr_addr,
  output logic [REG_WIDTH-1:0] wr_data,
  output logic                 wr_ena,
  input  logic [4:0]           rd_addr0,
  input  logic [4:0]           rd_addr1,
  input  logic [REG_WIDTH-1:0] rf_data0,
  input  logic [REG_WIDTH-1:0] rf_data1,
  output logic [REG_WIDTH-1:0] fwd_data0,
  output logic [REG_WIDTH-1:0] fwd_data1,
  output logic [CW-1:0]        count
);

  // Handshake: a result transfers on a cycle where valid && ready at the rising edge.
  // Readies depend only on occupancy and alu_valid, never on the pop this cycle.

  logic [4:0]           r_rd   [DEPTH];
  logic [REG_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_full;
  logic                 w_alu_fire;
  logic                 w_ld_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [4:0]           w_push_rd;
  logic [REG_WIDTH-1:0] w_push_data;

  assign w_full     = (r_count == CW'(DEPTH));
  assign alu_ready  = !w_full;
  assign ld_ready   = !w_full && !alu_valid;
  assign w_alu_fire = alu_valid && alu_ready;
  assign w_ld_fire  = ld_valid && ld_ready;

  always_comb begin
    w_push_rd   = ld_rd;
    w_push_data = ld_data;
    if (w_alu_fire) begin
      w_push_rd   = alu_rd;
      w_push_data = alu_data;
    end
  end

  // x0 results complete the handshake but never occupy a slot.
  assign w_push = (w_alu_fire || w_ld_fire) && (w_push_rd != 5'd0);
  assign w_pop  = (r_count != '0) && !hold;

  assign wr_ena  = w_pop;
  assign wr_addr = r_rd[r_rptr];
  assign wr_data = r_data[r_rptr];
  assign count   = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rd[r_wptr]   <= w_push_rd;
        r_data[r_wptr] <= w_push_data;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Scan from head (oldest) to tail so the youngest match overrides older ones;
  // the head being written this cycle still counts as a live entry.
  function automatic logic [REG_WIDTH-1:0] f_bypass(
    input logic [4:0]           addr,
    input logic [REG_WIDTH-1:0] rf
  );
    logic [REG_WIDTH-1:0] res;
    logic [PW-1:0]        idx;
    res = rf;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rptr + PW'(i);
      if ((CW'(i) < r_count) && (r_rd[idx] == addr)) begin
        res = r_data[idx];
      end
    end
    if (addr == 5'd0) begin
      res = '0;
    end
    return res;
  endfunction

  assign fwd_data0 = f_bypass(rd_addr0, rf_data0);
  assign fwd_data1 = f_bypass(rd_addr1, rf_data1);

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all checked
// against a queue-based reference model of the write-back buffer.
module tb_regfile_writeback;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid, ld_valid, hold;
  logic          alu_ready, ld_ready, wr_ena;
  logic [4:0]    alu_rd, ld_rd, rd_addr0, rd_addr1, wr_addr;
  logic [W-1:0]  alu_data, ld_data, rf_data0, rf_data1, wr_data, fwd_data0, fwd_data1;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes in acceptance order, oldest at index 0.
  logic [4:0]   m_rd[$];
  logic [W-1:0] m_data[$];

  regfile_writeback #(.REG_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .hold(hold),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rf_data0(rf_data0), .rf_data1(rf_data1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_fwd(input logic [4:0] addr, input logic [W-1:0] rf);
    if (addr == 5'd0) return '0;
    for (int i = m_rd.size() - 1; i >= 0; i--) begin
      if (m_rd[i] == addr) return m_data[i];
    end
    return rf;
  endfunction

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic offer_alu(input logic [4:0] rd, input logic [W-1:0] data);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
  endtask

  task automatic offer_ld(input logic [4:0] rd, input logic [W-1:0] data);
    ld_valid = 1'b1; ld_rd = rd; ld_data = data;
  endtask

  // Check every output at the falling edge, then advance the model across the rising edge.
  task automatic do_cycle();
    int   n;
    logic e_full, e_ar, e_lr, e_we;
    @(negedge clk);
    n      = m_rd.size();
    e_full = (n == D);
    e_ar   = !e_full;
    e_lr   = !e_full && !alu_valid;
    e_we   = (n != 0) && !hold;
    check("count", 64'(count), 64'(n));
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("ld_ready", 64'(ld_ready), 64'(e_lr));
    check("wr_ena", 64'(wr_ena), 64'(e_we));
    if (e_we) begin
      check("wr_addr", 64'(wr_addr), 64'(m_rd[0]));
      check("wr_data", 64'(wr_data), 64'(m_data[0]));
    end
    check("fwd_data0", 64'(fwd_data0), 64'(model_fwd(rd_addr0, rf_data0)));
    check("fwd_data1", 64'(fwd_data1), 64'(model_fwd(rd_addr1, rf_data1)));
    if (!rst) begin
      m_rd.delete();
      m_data.delete();
    end else begin
      if (e_we) begin
        m_rd.delete(0);
        m_data.delete(0);
      end
      if (alu_valid && e_ar) begin
        if (alu_rd != 5'd0) begin m_rd.push_back(alu_rd); m_data.push_back(alu_data); end
      end else if (ld_valid && e_lr) begin
        if (ld_rd != 5'd0) begin m_rd.push_back(ld_rd); m_data.push_back(ld_data); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    hold = 1'b0;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    rf_data0 = 32'h0000_1234; rf_data1 = 32'h0000_5678;

    // Reset: two cycles low, one of them with offers present.
    do_cycle();
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    offer_alu(5'd3, 32'h33); offer_ld(5'd9, 32'h99);
    rd_addr0 = 5'd3; rd_addr1 = 5'd9;
    do_cycle();
    idle();
    rst = 1'b1;

    // Single write.
    offer_alu(5'd5, 32'h0000_00AA);
    rd_addr0 = 5'd5;
    do_cycle();
    idle();
    check("t1_count_after_accept", 64'(count), 64'd1);
    do_cycle();
    check("t1_count_after_write", 64'(count), 64'd0);

    // Arbitration: ALU wins, load follows next cycle, writes r4 then r6.
    offer_alu(5'd4, 32'h11); offer_ld(5'd6, 32'h22);
    rd_addr0 = 5'd4; rd_addr1 = 5'd6;
    do_cycle();
    alu_valid = 1'b0;
    do_cycle();
    idle();
    repeat (3) do_cycle();

    // Full and hold.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer_alu(5'(i), 32'(i * 256));
      do_cycle();
    end
    offer_alu(5'd5, 32'h500);
    do_cycle();
    check("t3_full_count", 64'(count), 64'd4);
    idle();
    hold = 1'b0;
    repeat (5) do_cycle();
    check("t3_ready_after_drain", 64'(alu_ready), 64'd1);

    // x0 discard.
    offer_alu(5'd0, 32'hFFFF_FFFF);
    rd_addr0 = 5'd0;
    do_cycle();
    idle();
    check("t4_count_x0", 64'(count), 64'd0);
    check("t4_fwd_x0", 64'(fwd_data0), 64'd0);
    do_cycle();

    // Bypass youngest wins.
    hold = 1'b1;
    rd_addr1 = 5'd7; rf_data1 = 32'h9;
    offer_alu(5'd7, 32'h1);
    do_cycle();
    offer_alu(5'd7, 32'h2);
    do_cycle();
    idle();
    check("t5_fwd_youngest", 64'(fwd_data1), 64'h2);
    do_cycle();
    hold = 1'b0;
    repeat (3) do_cycle();
    check("t5_fwd_after_drain", 64'(fwd_data1), 64'h9);

    // Asynchronous reset mid-operation.
    hold = 1'b1;
    offer_alu(5'd10, 32'hA0); do_cycle();
    offer_alu(5'd11, 32'hB0); do_cycle();
    offer_alu(5'd12, 32'hC0); do_cycle();
    idle();
    check("t6_count_before", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("t6_count_async", 64'(count), 64'd0);
    check("t6_wr_ena_async", 64'(wr_ena), 64'd0);
    m_rd.delete();
    m_data.delete();
    #1 rst = 1'b1;
    hold = 1'b0;
    repeat (4) do_cycle();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 99) < 50);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 50);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      hold      = ($urandom_range(0, 99) < 25);
      rd_addr0  = 5'($urandom_range(0, 7));
      rd_addr1  = 5'($urandom_range(0, 7));
      rf_data0  = $urandom;
      rf_data1  = $urandom;
      do_cycle();
    end
    idle();
    hold = 1'b0;
    repeat (D + 1) do_cycle();
    check("final_empty", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
